// File: rtl/bit_word_assembler.sv
// Serial-to-parallel word assembler: pops bits from an upstream buffer on request and
// presents a WORD_W-bit word. Define BIT_WORD_ASSEMBLER_FILL_COUNT_EN to add fill_count.
module bit_word_assembler #(
  parameter int unsigned WORD_W       = 12,
  parameter int unsigned READY_CYCLES = 4,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          FILL_BIT     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_empty,
  input  logic              bit_data,
  output logic              bit_ack,
  input  logic              data_rq,
  output logic [WORD_W-1:0] data_out,
  output logic              data_ready,
  output logic              busy
`ifdef BIT_WORD_ASSEMBLER_FILL_COUNT_EN
  ,
  output logic [$clog2(WORD_W+1)-1:0] fill_count
`endif
);

  localparam int unsigned    CntW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WORD_W - 1);
  localparam logic [3:0]      RdyLast = 4'(READY_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StSend} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic              rq_front;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]   pos;
  logic [3:0]        rdy_cnt_q, rdy_cnt_d;
  logic              bit_q, bit_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_write;

  // data_rq is asynchronous; only sync_q[2:1] are safe to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], data_rq};
    end
  end

  assign rq_front   = sync_q[1] & ~sync_q[2];
  assign last_write = (state_q == StWrite) && (bit_cnt_q == LastIdx);

  always_comb begin
    pos = MSB_FIRST ? (LastIdx - bit_cnt_q) : bit_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rdy_cnt_d = rdy_cnt_q;
    bit_d     = bit_q;
    asm_d     = asm_q;
    data_d    = data_q;
    bit_ack   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rq_front) begin
          state_d   = StFetch;
          bit_cnt_d = '0;
          asm_d     = '0;
        end
      end
      StFetch: begin
        state_d = StWrite;
        if (!bit_empty) begin
          bit_d   = bit_data;
          bit_ack = 1'b1;
        end else begin
          bit_d = FILL_BIT;
        end
      end
      StWrite: begin
        asm_d[pos] = bit_q;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        if (last_write) begin
          data_d    = asm_d;
          bit_cnt_d = '0;
          rdy_cnt_d = '0;
          state_d   = StSend;
        end else begin
          state_d = StFetch;
        end
      end
      StSend: begin
        if (rdy_cnt_q == RdyLast) begin
          state_d = StIdle;
        end else begin
          rdy_cnt_d = rdy_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rdy_cnt_q <= '0;
      bit_q     <= 1'b0;
      asm_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rdy_cnt_q <= rdy_cnt_d;
      bit_q     <= bit_d;
      asm_q     <= asm_d;
      data_q    <= data_d;
    end
  end

  assign data_out   = data_q;
  assign data_ready = (state_q == StSend);
  assign busy       = (state_q != StIdle);

`ifdef BIT_WORD_ASSEMBLER_FILL_COUNT_EN
  localparam int unsigned FcW = $clog2(WORD_W + 1);

  logic [FcW-1:0] fill_cnt_q, fill_cnt_d;
  logic [FcW-1:0] fill_count_q, fill_count_d;

  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    fill_count_d = fill_count_q;
    if ((state_q == StIdle) && rq_front) begin
      fill_cnt_d = '0;
    end else if ((state_q == StFetch) && bit_empty) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
    // last FETCH precedes the last WRITE, so the count is already complete here
    if (last_write) begin
      fill_count_d = fill_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_q   <= '0;
      fill_count_q <= '0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign fill_count = fill_count_q;
`endif

endmodule

// File: doc/bit_word_assembler.md
BIT_WORD_ASSEMBLER -- requirements
Module: bit_word_assembler

Interface
REQ-001 Parameter WORD_W SHALL be declared with default 12; it sets the assembled word width, legal range 2..32.
REQ-002 Parameter READY_CYCLES SHALL be declared with default 4; it sets the data_ready pulse length in clocks, legal range 1..15.
REQ-003 Parameter MSB_FIRST SHALL be declared with default 1; 1 places the first bit fetched at bit WORD_W-1, 0 places it at bit 0.
REQ-004 Parameter FILL_BIT SHALL be declared with default 0; it is the value substituted for a bit when the source is empty.
REQ-005 Port clk SHALL be an input, 1 bit wide: the system clock (240 MHz).
REQ-006 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port bit_empty SHALL be an input, 1 bit wide: high when the upstream bit buffer holds no bit.
REQ-008 Port bit_data SHALL be an input, 1 bit wide: the head bit of the upstream buffer, valid while bit_empty is low.
REQ-009 Port bit_ack SHALL be an output, 1 bit wide: a one-clock pop strobe to the upstream buffer.
REQ-010 Port data_rq SHALL be an input, 1 bit wide: the word request, asynchronous to clk.
REQ-011 Port data_out SHALL be an output, WORD_W bits wide: the last completed word.
REQ-012 Port data_ready SHALL be an output, 1 bit wide: high while data_out holds a freshly completed word.
REQ-013 Port busy SHALL be an output, 1 bit wide: high in every state except IDLE.

Function
REQ-014 data_rq SHALL pass through a 3-flop synchroniser; a request front is sync[1]=1 and sync[2]=0.
REQ-015 The FSM SHALL use the states IDLE, FETCH, WRITE and SEND; it leaves reset in IDLE.
REQ-016 In IDLE, a request front SHALL move the FSM to FETCH on the same edge and clear the bit counter to 0.
REQ-017 In FETCH, if bit_empty=0 the block SHALL latch bit_data and drive bit_ack=1 for exactly one clock.
REQ-018 In FETCH, if bit_empty=1 the block SHALL latch FILL_BIT and keep bit_ack=0; FETCH always goes to WRITE next.
REQ-019 In WRITE, the block SHALL drive bit_ack=0, store the latched bit in the internal assembly register at the position given by MSB_FIRST and the counter, and increment the counter.
REQ-020 WRITE SHALL return to FETCH until WORD_W bits are stored, so that all WORD_W bits are written and none is skipped.
REQ-021 On the WRITE edge that stores bit WORD_W-1, the FSM SHALL load the full assembly register into data_out and move to SEND.
REQ-022 data_out SHALL stay stable at all other times, so the previous word remains readable during assembly.
REQ-023 In SEND, data_ready SHALL be 1 for exactly READY_CYCLES clocks; the FSM then returns to IDLE with data_ready=0.
REQ-024 Latency from the request-front clock to the first data_ready clock SHALL be 2*WORD_W+1 clocks.
REQ-025 Request fronts arriving outside IDLE SHALL be ignored and not queued.
REQ-026 A request front coinciding with the last SEND cycle SHALL also be ignored.
REQ-027 A source that goes empty mid-word SHALL yield a partial word padded with FILL_BIT, with no stall and no extra bit_ack.
REQ-028 bit_ack SHALL never be asserted on two consecutive clocks.
REQ-029 bit_ack SHALL never be asserted while bit_empty=1 was sampled in the same FETCH.

Reset
REQ-030 Asserting reset=0 SHALL set the state to IDLE and clear the synchroniser, counter, assembly register and latched bit.
REQ-031 Asserting reset=0 SHALL drive bit_ack=0, data_out=0, data_ready=0 and busy=0.
REQ-032 Reset asserted mid-word or mid-SEND SHALL abort immediately with no further bit_ack.
REQ-033 After release, the first request front SHALL start a clean word.

Configuration
REQ-034 With macro BIT_WORD_ASSEMBLER_FILL_COUNT_EN defined, the block SHALL add output fill_count, $clog2(WORD_W+1) bits wide, reset 0.
REQ-035 With the macro defined, fill_count SHALL be loaded together with data_out and equal the number of FILL_BIT substitutions in that word.
REQ-036 Without the macro, port fill_count and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-037 Scenario: defaults, source holds 12 bits 1,0,1,1,0,0,1,0,1,0,1,1, one data_rq pulse -> data_out=12'hB2B, 12 single-clock bit_ack pulses, data_ready high for 4 clocks, 25 clocks after the front.
REQ-038 Scenario: source holds 5 bits 1,1,1,1,1, FILL_BIT=0 -> data_out=12'hF80, 5 bit_ack pulses, and fill_count=7 when the macro is defined.
REQ-039 Scenario: MSB_FIRST=0, WORD_W=8, bits 1,0,0,0,0,0,0,0 -> data_out=8'h01.
REQ-040 Scenario: second data_rq rising edge during assembly -> ignored, exactly one word produced, busy continuously high until SEND ends.
REQ-041 Scenario: reset=0 asserted after 6 bits of a word -> all outputs 0 next clock, no bit_ack afterwards; the next request yields a full fresh word.
REQ-042 Scenario: READY_CYCLES=1, back-to-back requests spaced 40 clocks apart -> two words, each with a single-clock data_ready, previous data_out held until the next load.
